// File: rtl/tt_um_count_checker_pkg.sv
// Shared constants for the count-stream checker.
// State encoding, uio bit indices and status-bit positions.
package tt_um_count_checker_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int LOAD_B  = 0;
   localparam int VALID_B = 1;
   localparam int CLR_B   = 2;
   localparam int SEL_B   = 3;

   localparam int LOCKED_B = 7;
   localparam int PULSE_B  = 6;
   localparam int SAT_B    = 5;
   localparam int ACQ_B    = 4;

   localparam logic [7:0] OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_um_count_checker_sat_counter8.sv
// 8-bit saturating event counter with sync clear.
// sat goes high on the increment that lands on 0xFF.
module sat_counter8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] count,
   output logic       sat
);

   // count events, stick at 0xFF, clear has priority
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 8'h00;
         sat   <= 1'b0;
      end else if (ena) begin
         if (clr) begin
            count <= 8'h00;
            sat   <= 1'b0;
         end else if (inc && count != 8'hFF) begin
            count <= count + 8'd1;
            if (count == 8'hFE) sat <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tt_um_count_checker.sv
// Receive-side checker for a loadable 8-bit up-counter stream.
// Locks onto the +1 sequence, counts and captures sequence errors.
module tt_um_count_checker
   import tt_um_count_checker_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSE_COUNT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);
   localparam logic [2:0] LOSE_N = 3'(LOSE_COUNT);

   state_t     state;
   logic [7:0] expected;
   logic [2:0] good_cnt;
   logic [2:0] bad_cnt;
   logic [7:0] last_bad;
   logic       err_pulse;
   logic [7:0] err_count;
   logic       err_sat;

   logic load;
   logic valid;
   logic clr;
   logic sel;
   logic sample;
   logic match;
   logic err;
   logic [2:0] good_nxt;
   logic [2:0] bad_nxt;
   logic unused_bits;

   assign load   = uio_in[LOAD_B];
   assign valid  = uio_in[VALID_B];
   assign clr    = uio_in[CLR_B];
   assign sel    = uio_in[SEL_B];
   assign sample = ena & valid;
   assign match  = (ui_in == expected);
   assign err    = sample & (state == LOCKED) & ~match & ~load;

   assign good_nxt = good_cnt + 3'd1;
   assign bad_nxt  = bad_cnt + 3'd1;

   assign unused_bits = &{1'b0, uio_in[7:4]};

   // lock FSM, expected-value tracker and error capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= HUNT;
         expected  <= 8'h00;
         good_cnt  <= 3'd0;
         bad_cnt   <= 3'd0;
         last_bad  <= 8'h00;
         err_pulse <= 1'b0;
      end else if (ena) begin
         err_pulse <= err;
         if (clr) last_bad <= 8'h00;
         else if (err) last_bad <= ui_in;
         if (valid) begin
            expected <= ui_in + 8'd1;
            unique case (state)
               HUNT: begin
                  good_cnt <= 3'd1;
                  state    <= (LOCK_N == 3'd1) ? LOCKED : ACQUIRE;
               end
               ACQUIRE: begin
                  if (match || load) begin
                     good_cnt <= good_nxt;
                     if (good_nxt == LOCK_N) state <= LOCKED;
                  end else begin
                     good_cnt <= 3'd1;
                  end
               end
               LOCKED: begin
                  if (match || load) begin
                     bad_cnt <= 3'd0;
                  end else if (bad_nxt == LOSE_N) begin
                     state    <= HUNT;
                     good_cnt <= 3'd0;
                     bad_cnt  <= 3'd0;
                  end else begin
                     bad_cnt <= bad_nxt;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   sat_counter8 u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .clr   (clr),
      .inc   (err),
      .count (err_count),
      .sat   (err_sat)
   );

   // output mux and status byte
   always_comb begin
      uo_out            = sel ? last_bad : err_count;
      uio_out           = 8'h00;
      uio_out[LOCKED_B] = (state == LOCKED);
      uio_out[PULSE_B]  = err_pulse;
      uio_out[SAT_B]    = err_sat;
      uio_out[ACQ_B]    = (state == ACQUIRE);
   end

   assign uio_oe = OE_MASK;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Bench for tt_um_count_checker: vector table plus corner sequences.
// Expected outputs are queued at drive time and popped after the edge.
module tb_tt_um_count_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp = 0;
   int n_bad = 0;
   int step  = 0;

   typedef struct packed {
      logic       r;
      logic       e;
      logic [7:0] ui;
      logic       ld;
      logic       vl;
      logic       cl;
      logic       sl;
      logic [3:0] ph;
      logic [7:0] xuo;
      logic [7:0] xuio;
   } vec_t;

   typedef struct packed {
      logic [3:0] ph;
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   tt_um_count_checker dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   function automatic string ph_name(input logic [3:0] p);
      case (p)
         4'd0: return "reset";
         4'd1: return "acquire";
         4'd2: return "wrap";
         4'd3: return "single_err";
         4'd4: return "load";
         4'd5: return "loss";
         4'd6: return "saturate";
         4'd7: return "clear";
         4'd8: return "enable";
         4'd9: return "mid_reset";
         default: return "other";
      endcase
   endfunction

   function automatic vec_t mk(
      input logic r, input logic e, input logic [7:0] u,
      input logic ld, input logic vl, input logic cl, input logic sl,
      input logic [3:0] p, input logic [7:0] xo, input logic [7:0] xs);
      vec_t v;
      v = '{r, e, u, ld, vl, cl, sl, p, xo, xs};
      return v;
   endfunction

   task automatic apply(input vec_t v);
      exp_t x;
      rst_n  = v.r;
      ena    = v.e;
      ui_in  = v.ui;
      uio_in = {4'h0, v.sl, v.cl, v.vl, v.ld};
      sb.push_back('{v.ph, v.xuo, v.xuio});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      n_cmp++;
      step++;
      if (uo_out !== x.uo || uio_out !== x.uio) begin
         n_bad++;
         $display("FAIL %s step %0d: uo_out=%h uio_out=%h want uo_out=%h uio_out=%h",
                  ph_name(x.ph), step, uo_out, uio_out, x.uo, x.uio);
      end
   endtask

   initial begin
      logic [7:0] nx;
      logic [7:0] e;
      logic [7:0] lb;
      logic [7:0] c;
      logic [7:0] s;

      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      @(negedge clk);

      // reset, acquire and lock
      tbl.push_back(mk(0,1,8'h00, 0,0,0,0, 0, 8'h00,8'h00));
      tbl.push_back(mk(1,1,8'h10, 0,1,0,0, 1, 8'h00,8'h10));
      tbl.push_back(mk(1,1,8'h11, 0,1,0,0, 1, 8'h00,8'h10));
      tbl.push_back(mk(1,1,8'h12, 0,1,0,0, 1, 8'h00,8'h10));
      tbl.push_back(mk(1,1,8'h13, 0,1,0,0, 1, 8'h00,8'h80));
      // reload to 0xFE, then wrap through 0x00
      tbl.push_back(mk(1,1,8'hFE, 1,1,0,0, 2, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'hFF, 0,1,0,0, 2, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'h00, 0,1,0,0, 2, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'h01, 0,1,0,0, 2, 8'h00,8'h80));
      // single error and resync
      tbl.push_back(mk(1,1,8'h1F, 1,1,0,0, 3, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'h25, 0,1,0,0, 3, 8'h01,8'hC0));
      tbl.push_back(mk(1,1,8'h26, 0,1,0,1, 3, 8'h25,8'h80));
      tbl.push_back(mk(1,1,8'h00, 0,0,0,0, 3, 8'h01,8'h80));
      // clear stats, then load accepted
      tbl.push_back(mk(1,1,8'h00, 0,0,1,0, 4, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'h2F, 1,1,0,0, 4, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'h80, 1,1,0,0, 4, 8'h00,8'h80));
      tbl.push_back(mk(1,1,8'h81, 0,1,0,0, 4, 8'h00,8'h80));
      // three errors drop lock
      tbl.push_back(mk(1,1,8'h10, 0,1,0,0, 5, 8'h01,8'hC0));
      tbl.push_back(mk(1,1,8'h50, 0,1,0,0, 5, 8'h02,8'hC0));
      tbl.push_back(mk(1,1,8'h90, 0,1,0,0, 5, 8'h03,8'h40));
      tbl.push_back(mk(1,1,8'h00, 0,0,0,1, 5, 8'h90,8'h00));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         if (i == 0) begin
            n_cmp++;
            if (uio_oe !== 8'hF0) begin
               n_bad++;
               $display("FAIL uio_oe: got %h want f0", uio_oe);
            end
         end
      end

      // relock with clear, then 300 errors alternating with matches
      apply(mk(1,1,8'h40, 0,1,1,0, 6, 8'h00,8'h10));
      apply(mk(1,1,8'h41, 0,1,0,0, 6, 8'h00,8'h10));
      apply(mk(1,1,8'h42, 0,1,0,0, 6, 8'h00,8'h10));
      apply(mk(1,1,8'h43, 0,1,0,0, 6, 8'h00,8'h80));
      nx = 8'h44;
      lb = 8'h00;
      for (int i = 0; i < 300; i++) begin
         e  = nx + 8'd3;
         lb = e;
         c  = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
         s  = (c == 8'hFF) ? 8'h20 : 8'h00;
         apply(mk(1,1,e, 0,1,0,0, 6, c, 8'hC0 | s));
         apply(mk(1,1,e + 8'd1, 0,1,0,0, 6, c, 8'h80 | s));
         nx = e + 8'd2;
      end
      apply(mk(1,1,8'h00, 0,0,0,1, 7, lb, 8'hA0));
      apply(mk(1,1,8'h00, 0,0,1,0, 7, 8'h00, 8'h80));
      // clear on the same edge as an error
      e = nx + 8'd3;
      apply(mk(1,1,e, 0,1,1,0, 7, 8'h00, 8'hC0));
      apply(mk(1,1,8'h00, 0,0,0,1, 7, 8'h00, 8'h80));
      nx = e + 8'd1;

      // error, then freeze with ena low (pulse stretches)
      e = nx + 8'd3;
      apply(mk(1,1,e, 0,1,0,0, 8, 8'h01, 8'hC0));
      nx = e + 8'd1;
      for (int k = 0; k < 5; k++) begin
         apply(mk(1,0,8'($urandom), 0, k[0], (k == 2), 0,
                  8, 8'h01, 8'hC0));
      end
      apply(mk(1,1,8'h00, 0,0,0,0, 8, 8'h01, 8'h80));
      apply(mk(1,1,nx, 0,1,0,0, 8, 8'h01, 8'h80));

      // reset beats ena, then reset during ACQUIRE
      apply(mk(0,0,8'h00, 0,0,0,0, 9, 8'h00, 8'h00));
      apply(mk(1,1,8'h60, 0,1,0,0, 9, 8'h00, 8'h10));
      apply(mk(1,1,8'h61, 0,1,0,0, 9, 8'h00, 8'h10));
      apply(mk(0,1,8'h62, 0,1,0,0, 9, 8'h00, 8'h00));
      apply(mk(1,1,8'h62, 0,1,0,0, 9, 8'h00, 8'h10));
      apply(mk(1,1,8'h63, 0,1,0,0, 9, 8'h00, 8'h10));
      apply(mk(1,1,8'h64, 0,1,0,0, 9, 8'h00, 8'h10));
      apply(mk(1,1,8'h65, 0,1,0,0, 9, 8'h00, 8'h80));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
